// File: rtl/ysyx_20020207_pkg.sv
// Shared definitions for the ysyx_20020207 AXI4-lite requester arbiter.
//   arb_state_e : arbiter FSM state encoding
//   REQ_*       : requester slot indices on the arbiter ports
//   OKAY/SLVERR : AXI response codes seen on rresp/bresp
package ysyx_20020207_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4
  } arb_state_e;

  localparam int REQ_IFU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_DBG = 2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_20020207_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority this round
//   win   : one-hot winner (zero when nothing requests)
//   valid : at least one requester is requesting
module ysyx_20020207_rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);

  // Walk offsets 0..N-1 from ptr; the first requesting slot wins.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid && req[i] && (i == ((int'(ptr) + k) % N))) begin
          win[i] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_20020207_rr_arbiter.sv
// Round-robin AXI4-lite arbiter: shares one master port between N_REQ
// requesters (0 = IFU, 1 = LSU, 2 = debug), one whole transaction at a time.
//   clk, rst     : clock, asynchronous active-low reset
//   req_*        : per-requester AXI4-lite slave-side channels (flattened)
//   m_*          : single AXI4-lite master port toward the XBAR
//   grant        : one-hot current owner, zero while idle
//   busy         : a transaction is in progress
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | no owner; pick next requester from rr_ptr
// ST_RADDR | forwarding AR of the owner
// ST_RDATA | routing R back to the owner
// ST_WADDR | forwarding AW and W of the owner, each until its handshake
// ST_WRESP | routing B back to the owner
module ysyx_20020207_rr_arbiter
  import ysyx_20020207_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_arvalid,
  output logic [N_REQ-1:0]        req_arready,
  input  logic [N_REQ*AW-1:0]     req_araddr,
  input  logic [N_REQ*3-1:0]      req_arsize,
  output logic [N_REQ-1:0]        req_rvalid,
  input  logic [N_REQ-1:0]        req_rready,
  output logic [N_REQ*DW-1:0]     req_rdata,
  output logic [N_REQ*2-1:0]      req_rresp,
  input  logic [N_REQ-1:0]        req_awvalid,
  output logic [N_REQ-1:0]        req_awready,
  input  logic [N_REQ*AW-1:0]     req_awaddr,
  input  logic [N_REQ*3-1:0]      req_awsize,
  input  logic [N_REQ-1:0]        req_wvalid,
  output logic [N_REQ-1:0]        req_wready,
  input  logic [N_REQ*DW-1:0]     req_wdata,
  input  logic [N_REQ*DW/8-1:0]   req_wstrb,
  output logic [N_REQ-1:0]        req_bvalid,
  input  logic [N_REQ-1:0]        req_bready,
  output logic [N_REQ*2-1:0]      req_bresp,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [AW-1:0]           m_araddr,
  output logic [2:0]              m_arsize,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DW-1:0]           m_rdata,
  input  logic [1:0]              m_rresp,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [AW-1:0]           m_awaddr,
  output logic [2:0]              m_awsize,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DW-1:0]           m_wdata,
  output logic [DW/8-1:0]         m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = DW / 8;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;

  logic [N_REQ-1:0] pick_win;
  logic             pick_valid;
  logic [PW-1:0]    rot_ptr;

  ysyx_20020207_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req   (req_arvalid | req_awvalid),
    .ptr   (rr_ptr_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= PW'(REQ_IFU);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_arsize  = '0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awsize  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_bready  = 1'b0;

    req_arready = '0;
    req_rvalid  = '0;
    req_rdata   = '0;
    req_rresp   = '0;
    req_awready = '0;
    req_wready  = '0;
    req_bvalid  = '0;
    req_bresp   = '0;

    // Priority after this transaction: slot just past the current owner.
    rot_ptr = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) rot_ptr = PW'((i + 1) % N_REQ);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_win;
          // a requester asserting both gets its read serviced first
          state_d = (|(pick_win & req_arvalid)) ? ST_RADDR : ST_WADDR;
        end
      end

      ST_RADDR: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_q[i]) begin
            m_arvalid      = req_arvalid[i];
            m_araddr       = req_araddr[i*AW +: AW];
            m_arsize       = req_arsize[i*3 +: 3];
            req_arready[i] = m_arready;
          end
        end
        if (m_arvalid && m_arready) state_d = ST_RDATA;
      end

      ST_RDATA: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_q[i]) begin
            m_rready            = req_rready[i];
            req_rvalid[i]       = m_rvalid;
            req_rdata[i*DW +: DW] = m_rdata;
            req_rresp[i*2 +: 2] = m_rresp;
          end
        end
        if (m_rvalid && m_rready) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = rot_ptr;
        end
      end

      ST_WADDR: begin
        // AW and W complete independently; a finished channel stays quiet.
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_q[i]) begin
            m_awvalid      = req_awvalid[i] & ~aw_done_q;
            m_awaddr       = req_awaddr[i*AW +: AW];
            m_awsize       = req_awsize[i*3 +: 3];
            req_awready[i] = m_awready & ~aw_done_q;
            m_wvalid       = req_wvalid[i] & ~w_done_q;
            m_wdata        = req_wdata[i*DW +: DW];
            m_wstrb        = req_wstrb[i*SW +: SW];
            req_wready[i]  = m_wready & ~w_done_q;
          end
        end
        aw_done_d = aw_done_q | (m_awvalid & m_awready);
        w_done_d  = w_done_q | (m_wvalid & m_wready);
        if (aw_done_d && w_done_d) begin
          state_d   = ST_WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      ST_WRESP: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_q[i]) begin
            m_bready            = req_bready[i];
            req_bvalid[i]       = m_bvalid;
            req_bresp[i*2 +: 2] = m_bresp;
          end
        end
        if (m_bvalid && m_bready) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = rot_ptr;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_20020207_rr_arbiter.sv
// Bench for ysyx_20020207_rr_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_ysyx_20020207_rr_arbiter;
  import ysyx_20020207_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      req_arvalid, req_arready, req_rvalid, req_rready;
  logic [N*AW-1:0]   req_araddr, req_awaddr;
  logic [N*3-1:0]    req_arsize, req_awsize;
  logic [N*DW-1:0]   req_rdata, req_wdata;
  logic [N*2-1:0]    req_rresp, req_bresp;
  logic [N-1:0]      req_awvalid, req_awready, req_wvalid, req_wready;
  logic [N*DW/8-1:0] req_wstrb;
  logic [N-1:0]      req_bvalid, req_bready;
  logic              m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]     m_araddr, m_awaddr;
  logic [2:0]        m_arsize, m_awsize;
  logic [DW-1:0]     m_rdata, m_wdata;
  logic [1:0]        m_rresp, m_bresp;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [DW/8-1:0]   m_wstrb;
  logic [N-1:0]      grant;
  logic              busy;

  ysyx_20020207_rr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
    .req_arsize(req_arsize), .req_rvalid(req_rvalid), .req_rready(req_rready),
    .req_rdata(req_rdata), .req_rresp(req_rresp),
    .req_awvalid(req_awvalid), .req_awready(req_awready), .req_awaddr(req_awaddr),
    .req_awsize(req_awsize), .req_wvalid(req_wvalid), .req_wready(req_wready),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_bvalid(req_bvalid), .req_bready(req_bready), .req_bresp(req_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awsize(m_awsize),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .grant(grant), .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, whether it is a read or a
  // write, and how far that transaction has progressed.
  int md_owner = -1;
  int md_ptr   = 0;
  bit md_rd    = 1'b0;
  bit md_a     = 1'b0;   // address handshake done
  bit md_w     = 1'b0;   // write data handshake done
  bit md_resp  = 1'b0;   // waiting for write response

  logic [N-1:0]    e_grant, e_req_arready, e_req_rvalid, e_req_awready, e_req_wready, e_req_bvalid;
  logic            e_busy, e_m_arvalid, e_m_rready, e_m_awvalid, e_m_wvalid, e_m_bready;
  logic [AW-1:0]   e_m_araddr, e_m_awaddr;
  logic [2:0]      e_m_arsize, e_m_awsize;
  logic [DW-1:0]   e_m_wdata;
  logic [DW/8-1:0] e_m_wstrb;
  logic [N*DW-1:0] e_req_rdata;
  logic [N*2-1:0]  e_req_rresp, e_req_bresp;

  task automatic model_eval();
    e_grant = '0; e_busy = 1'b0;
    e_m_arvalid = 1'b0; e_m_araddr = '0; e_m_arsize = '0; e_m_rready = 1'b0;
    e_m_awvalid = 1'b0; e_m_awaddr = '0; e_m_awsize = '0;
    e_m_wvalid = 1'b0; e_m_wdata = '0; e_m_wstrb = '0; e_m_bready = 1'b0;
    e_req_arready = '0; e_req_rvalid = '0; e_req_rdata = '0; e_req_rresp = '0;
    e_req_awready = '0; e_req_wready = '0; e_req_bvalid = '0; e_req_bresp = '0;
    for (int i = 0; i < N; i++) begin
      if (i == md_owner) begin
        e_grant[i] = 1'b1;
        e_busy = 1'b1;
        if (md_rd && !md_a) begin
          e_m_arvalid = req_arvalid[i];
          e_m_araddr = req_araddr[i*AW +: AW];
          e_m_arsize = req_arsize[i*3 +: 3];
          e_req_arready[i] = m_arready;
        end else if (md_rd) begin
          e_m_rready = req_rready[i];
          e_req_rvalid[i] = m_rvalid;
          e_req_rdata[i*DW +: DW] = m_rdata;
          e_req_rresp[i*2 +: 2] = m_rresp;
        end else if (!md_resp) begin
          e_m_awvalid = req_awvalid[i] && !md_a;
          e_m_awaddr = req_awaddr[i*AW +: AW];
          e_m_awsize = req_awsize[i*3 +: 3];
          e_req_awready[i] = m_awready && !md_a;
          e_m_wvalid = req_wvalid[i] && !md_w;
          e_m_wdata = req_wdata[i*DW +: DW];
          e_m_wstrb = req_wstrb[i*(DW/8) +: DW/8];
          e_req_wready[i] = m_wready && !md_w;
        end else begin
          e_m_bready = req_bready[i];
          e_req_bvalid[i] = m_bvalid;
          e_req_bresp[i*2 +: 2] = m_bresp;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_owner = -1; md_ptr = 0; md_rd = 1'b0; md_a = 1'b0; md_w = 1'b0; md_resp = 1'b0;
    end else begin
      model_eval();
      if (md_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          for (int i = 0; i < N; i++) begin
            if (md_owner < 0 && i == (md_ptr + k) % N && (req_arvalid[i] || req_awvalid[i])) begin
              md_owner = i;
              md_rd = req_arvalid[i];
            end
          end
        end
      end else if (md_rd && !md_a) begin
        assert (e_m_arvalid) else $error("FAIL stimulus: arvalid dropped after grant");
        if (e_m_arvalid && m_arready) md_a = 1'b1;
      end else if (md_rd) begin
        if (m_rvalid && e_m_rready) begin
          md_ptr = (md_owner + 1) % N; md_owner = -1; md_a = 1'b0;
        end
      end else if (!md_resp) begin
        if (e_m_awvalid && m_awready) md_a = 1'b1;
        if (e_m_wvalid && m_wready) md_w = 1'b1;
        if (md_a && md_w) begin md_resp = 1'b1; md_a = 1'b0; md_w = 1'b0; end
      end else if (m_bvalid && e_m_bready) begin
        md_ptr = (md_owner + 1) % N; md_owner = -1; md_resp = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      model_eval();
      chk("grant", 128'(grant), 128'(e_grant));
      chk("busy", 128'(busy), 128'(e_busy));
      chk("m_ar", 128'({m_arvalid, m_arsize, m_araddr}), 128'({e_m_arvalid, e_m_arsize, e_m_araddr}));
      chk("m_rready", 128'(m_rready), 128'(e_m_rready));
      chk("m_aw", 128'({m_awvalid, m_awsize, m_awaddr}), 128'({e_m_awvalid, e_m_awsize, e_m_awaddr}));
      chk("m_w", 128'({m_wvalid, m_wstrb, m_wdata}), 128'({e_m_wvalid, e_m_wstrb, e_m_wdata}));
      chk("m_bready", 128'(m_bready), 128'(e_m_bready));
      chk("req_arready", 128'(req_arready), 128'(e_req_arready));
      chk("req_r", 128'({req_rvalid, req_rresp, req_rdata}), 128'({e_req_rvalid, e_req_rresp, e_req_rdata}));
      chk("req_awready", 128'(req_awready), 128'(e_req_awready));
      chk("req_wready", 128'(req_wready), 128'(e_req_wready));
      chk("req_b", 128'({req_bvalid, req_bresp}), 128'({e_req_bvalid, e_req_bresp}));
      chk("ar_aw_exclusive", 128'(m_arvalid & m_awvalid), 128'(0));
    end
  end

  task automatic clear_inputs();
    req_arvalid = '0; req_araddr = '0; req_arsize = '0; req_rready = '0;
    req_awvalid = '0; req_awaddr = '0; req_awsize = '0;
    req_wvalid = '0; req_wdata = '0; req_wstrb = '0; req_bready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  bit rd_act[N], wr_act[N], w_iss[N];
  int wdl[N];
  logic [N-1:0] ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [2:0] exp3[3];

  initial begin
    clear_inputs();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid_ready", 128'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
        req_arready, req_rvalid, req_awready, req_wready, req_bvalid}), 128'(0));

    // Single LSU read
    req_arvalid[REQ_LSU] = 1'b1;
    req_araddr[REQ_LSU*AW +: AW] = 32'h8000_0000;
    req_arsize[REQ_LSU*3 +: 3] = 3'd2;
    req_rready[REQ_LSU] = 1'b1;
    m_arready = 1'b1;
    tick(); #1;
    chk("lsu_rd_grant", 128'(grant), 128'(3'b010));
    chk("lsu_rd_arvalid", 128'(m_arvalid), 128'(1));
    chk("lsu_rd_araddr", 128'(m_araddr), 128'(32'h8000_0000));
    tick();
    req_arvalid = '0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = OKAY;
    #1;
    chk("lsu_rd_rvalid", 128'(req_rvalid), 128'(3'b010));
    chk("lsu_rd_rdata", 128'(req_rdata[REQ_LSU*DW +: DW]), 128'(32'hDEAD_BEEF));
    chk("lsu_rd_rresp", 128'(req_rresp[REQ_LSU*2 +: 2]), 128'(OKAY));
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("lsu_rd_busy_after", 128'(busy), 128'(0));
    chk("lsu_rd_grant_after", 128'(grant), 128'(0));

    // Three requesters with rr_ptr = 2 after the LSU read
    exp3[0] = 3'b100; exp3[1] = 3'b001; exp3[2] = 3'b010;
    req_arvalid = 3'b111; req_rready = 3'b111;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c % 3 == 1) begin
        #1 chk("three_way_order", 128'(grant), 128'(exp3[(c - 1) / 3]));
      end
      if (c == 8) req_arvalid = '0;
    end
    tick();
    clear_inputs();

    // IFU and LSU reading continuously from reset, reset pulsed in LSU RDATA
    do_reset();
    req_arvalid = 3'b011; req_rready = 3'b011;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001;
    for (int c = 1; c <= 11; c++) begin
      tick();
      #1;
      if (c % 3 == 1) chk("alternate_grant", 128'(grant), 128'((((c - 1) / 3) % 2 == 1) ? 3'b010 : 3'b001));
      chk("grant_onehot", 128'($countones(grant) <= 1), 128'(1));
    end
    chk("pre_rst_busy", 128'(busy), 128'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_grant", 128'(grant), 128'(0));
    chk("mid_rst_rvalid", 128'(req_rvalid), 128'(0));
    @(posedge clk);
    #2 rst = 1'b1;
    tick(); #1;
    chk("post_rst_grant_ifu", 128'(grant), 128'(3'b001));
    req_arvalid = 3'b001;
    tick();
    req_arvalid = '0;
    tick();
    clear_inputs();

    // LSU write, W arrives 3 cycles after AW, SLVERR response
    req_awvalid[REQ_LSU] = 1'b1;
    req_awaddr[REQ_LSU*AW +: AW] = 32'h8000_0010;
    req_awsize[REQ_LSU*3 +: 3] = 3'd2;
    req_bready[REQ_LSU] = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1;
    tick(); #1;
    chk("wr_grant", 128'(grant), 128'(3'b010));
    chk("wr_awvalid", 128'(m_awvalid), 128'(1));
    chk("wr_wvalid_early", 128'(m_wvalid), 128'(0));
    tick(); #1;
    chk("wr_awvalid_forced_low", 128'(m_awvalid), 128'(0));
    tick(); #1;
    chk("wr_still_busy", 128'(busy), 128'(1));
    tick();
    req_wvalid[REQ_LSU] = 1'b1;
    req_wdata[REQ_LSU*DW +: DW] = 32'h0BAD_F00D;
    req_wstrb[REQ_LSU*(DW/8) +: DW/8] = 4'hF;
    #1;
    chk("wr_wvalid", 128'(m_wvalid), 128'(1));
    chk("wr_awvalid_still_low", 128'(m_awvalid), 128'(0));
    tick();
    req_awvalid = '0; req_wvalid = '0;
    m_bvalid = 1'b1; m_bresp = SLVERR;
    #1;
    chk("wr_bvalid", 128'(req_bvalid), 128'(3'b010));
    chk("wr_bresp", 128'(req_bresp[REQ_LSU*2 +: 2]), 128'(SLVERR));
    tick();
    m_bvalid = 1'b0;
    #1 chk("wr_busy_after", 128'(busy), 128'(0));
    clear_inputs();

    // Same requester asserts read and write together
    req_arvalid[REQ_LSU] = 1'b1; req_awvalid[REQ_LSU] = 1'b1; req_wvalid[REQ_LSU] = 1'b1;
    req_araddr[REQ_LSU*AW +: AW] = 32'h8000_0100;
    req_awaddr[REQ_LSU*AW +: AW] = 32'h8000_0200;
    req_rready = 3'b111; req_bready = 3'b111;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1; m_rvalid = 1'b1; m_bvalid = 1'b1;
    tick(); #1;
    chk("both_read_first", 128'({m_arvalid, m_awvalid}), 128'(2'b10));
    tick();
    req_arvalid = '0;
    tick();
    tick(); #1;
    chk("both_write_next", 128'({grant, m_awvalid, m_wvalid}), 128'(5'b01011));
    chk("both_awaddr", 128'(m_awaddr), 128'(32'h8000_0200));
    tick();
    req_awvalid = '0; req_wvalid = '0;
    #1 chk("both_bvalid", 128'(req_bvalid), 128'(3'b010));
    tick();
    clear_inputs();
    #1 chk("both_busy_after", 128'(busy), 128'(0));

    // Randomized traffic
    for (int i = 0; i < N; i++) begin rd_act[i] = 0; wr_act[i] = 0; w_iss[i] = 0; wdl[i] = 0; end
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      #1;
      ar_hs = req_arvalid & req_arready;
      r_hs  = req_rvalid & req_rready;
      aw_hs = req_awvalid & req_awready;
      w_hs  = req_wvalid & req_wready;
      b_hs  = req_bvalid & req_bready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (ar_hs[i]) req_arvalid[i] = 1'b0;
        if (r_hs[i]) rd_act[i] = 1'b0;
        if (!rd_act[i] && $urandom_range(3) == 0) begin
          rd_act[i] = 1'b1;
          req_arvalid[i] = 1'b1;
          req_araddr[i*AW +: AW] = $urandom;
          req_arsize[i*3 +: 3] = 3'($urandom_range(2));
        end
        req_rready[i] = ($urandom_range(3) != 0);
        if (aw_hs[i]) req_awvalid[i] = 1'b0;
        if (w_hs[i]) req_wvalid[i] = 1'b0;
        if (b_hs[i]) wr_act[i] = 1'b0;
        if (!wr_act[i] && $urandom_range(4) == 0) begin
          wr_act[i] = 1'b1;
          w_iss[i] = 1'b0;
          wdl[i] = $urandom_range(3);
          req_awvalid[i] = 1'b1;
          req_awaddr[i*AW +: AW] = $urandom;
          req_awsize[i*3 +: 3] = 3'($urandom_range(2));
        end
        if (wr_act[i] && !w_iss[i]) begin
          if (wdl[i] == 0) begin
            req_wvalid[i] = 1'b1;
            req_wdata[i*DW +: DW] = $urandom;
            req_wstrb[i*(DW/8) +: DW/8] = 4'($urandom_range(15));
            w_iss[i] = 1'b1;
          end else begin
            wdl[i]--;
          end
        end
        req_bready[i] = ($urandom_range(3) != 0);
      end
      m_arready = 1'($urandom_range(1));
      m_awready = 1'($urandom_range(1));
      m_wready  = 1'($urandom_range(1));
      m_rvalid  = 1'($urandom_range(1));
      m_rdata   = $urandom;
      m_rresp   = ($urandom_range(1) == 1) ? SLVERR : OKAY;
      m_bvalid  = 1'($urandom_range(1));
      m_bresp   = ($urandom_range(1) == 1) ? SLVERR : OKAY;
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
